mux_pipe_n: RTL and testbench

- Parametrised, pipelined N:1 word selector; successor to the 16:1 single-bit combinational mux.
- Adds configurable data width and input count, two register stages (group pre-select, then final select) and valid/ready flow control.
- Flags out-of-range selects and keeps a saturating count of them.
- Sits between HLS datapath operand banks and DMA/compute consumers where a wide mux must meet timing.

---
 rtl/mux_pipe_n.sv | 146 ++++++++++++++
 tb/tb_mux_pipe_n.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: two-stage pipelined NUM_IN:1 word selector with valid/ready flow control.
// Rev 1.0 - group pre-select stage, final select stage, saturating out-of-range counter.
`default_nettype none

module mux_pipe_n #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 16,
  parameter int SEL_W     = 4,
  parameter int GROUP     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam int                   C_NG      = (NUM_IN + GROUP - 1) / GROUP;
  localparam int                   C_LOG_G   = $clog2(GROUP);
  localparam logic [SEL_W:0]       C_NUM_IN  = (SEL_W + 1)'(NUM_IN);
  localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = '1;

  if (2 ** SEL_W < NUM_IN) begin : g_sel_w_check
    $error("mux_pipe_n: SEL_W too narrow to address NUM_IN inputs");
  end

  // Input words padded out to a whole number of groups; padding reads as zero.
  logic [WIDTH-1:0] w_word [C_NG*GROUP];

  for (genvar i = 0; i < C_NG * GROUP; i++) begin : g_word
    if (i < NUM_IN) begin : g_real
      assign w_word[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_word[i] = '0;
    end
  end

  logic [SEL_W-1:0] w_lo;
  logic [SEL_W-1:0] w_hi;
  logic             w_err;
  logic [WIDTH-1:0] w_cand [C_NG];
  logic [WIDTH-1:0] w_pick;
  logic             w_accept;
  logic             w_s2_load;

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     cand_q [C_NG];
  logic [WIDTH-1:0]     cand_d [C_NG];
  logic [SEL_W-1:0]     hi_q, hi_d;
  logic                 err1_q, err1_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign w_lo  = sel & SEL_W'(GROUP - 1);
  assign w_hi  = sel >> C_LOG_G;
  assign w_err = ({1'b0, sel} >= C_NUM_IN);

  always_comb begin
    for (int g = 0; g < C_NG; g++) begin
      w_cand[g] = '0;
      for (int k = 0; k < GROUP; k++) begin
        if (w_lo == SEL_W'(k)) w_cand[g] = w_word[g*GROUP + k];
      end
    end
  end

  always_comb begin
    w_pick = '0;
    for (int g = 0; g < C_NG; g++) begin
      if (hi_q == SEL_W'(g)) w_pick = cand_q[g];
    end
  end

  assign w_s2_load = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    cand_d      = cand_q;
    hi_d        = hi_q;
    err1_d      = err1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;

    if (w_accept) begin
      s1_valid_d = 1'b1;
      cand_d     = w_cand;
      hi_d       = w_hi;
      err1_d     = w_err;
    end else if (w_s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Output data holds its last value when the beat drains without a refill.
    if (w_s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = err1_q ? '0 : w_pick;
      out_err_d   = err1_q;
      if (err1_q && (err_count_q != C_CNT_MAX)) err_count_d = err_count_q + ERR_CNT_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      for (int g = 0; g < C_NG; g++) cand_q[g] <= '0;
      hi_q        <= '0;
      err1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      for (int g = 0; g < C_NG; g++) cand_q[g] <= cand_d[g];
      hi_q        <= hi_d;
      err1_q      <= err1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: directed checks of mux_pipe_n in three configurations plus a scoreboard stream.
`default_nettype none

module tb_mux_pipe_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: default configuration
  logic [16*32-1:0] a_in_data;
  logic [3:0]       a_sel;
  logic             a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
  logic [31:0]      a_out_data;
  logic [7:0]       a_err_count;

  mux_pipe_n u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_err(a_out_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .err_count(a_err_count)
  );

  // Instance B: 12 inputs, 2-bit error counter
  logic [12*32-1:0] b_in_data;
  logic [3:0]       b_sel;
  logic             b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
  logic [31:0]      b_out_data;
  logic [1:0]       b_err_count;

  mux_pipe_n #(.WIDTH(32), .NUM_IN(12), .SEL_W(4), .GROUP(4), .ERR_CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_err(b_out_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .err_count(b_err_count)
  );

  // Instance C: 8-bit words, 5 inputs, groups of 2 (last group partial)
  logic [5*8-1:0] c_in_data;
  logic [2:0]     c_sel;
  logic           c_in_valid, c_in_ready, c_out_err, c_out_valid, c_out_ready;
  logic [7:0]     c_out_data;
  logic [7:0]     c_err_count;

  mux_pipe_n #(.WIDTH(8), .NUM_IN(5), .SEL_W(3), .GROUP(2), .ERR_CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .sel(c_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_err(c_out_err),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .err_count(c_err_count)
  );

  int          t2_sel [3] = '{3, 7, 11};
  logic [31:0] t2_exp [3] = '{32'h1003, 32'h1007, 32'h100B};
  int          t3_sel [3] = '{12, 15, 5};
  logic [31:0] t3_dat [3] = '{32'h0, 32'h0, 32'h1005};
  logic        t3_err [3] = '{1'b1, 1'b1, 1'b0};
  logic [1:0]  t3_cnt [3] = '{2'd1, 2'd2, 2'd2};
  logic [1:0]  t4_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected run to complete");
    $fatal(1);
  end

  initial begin
    int k, m, sent, got, errs;
    logic [8:0] q[$];
    logic [8:0] exp_beat;

    a_in_valid = 1'b1; a_sel = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_sel = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_sel = '0; c_out_ready = 1'b1; c_in_data = '0;
    for (int i = 0; i < 16; i++) a_in_data[i*32 +: 32] = 32'h1000 + i;
    for (int i = 0; i < 12; i++) b_in_data[i*32 +: 32] = 32'h1000 + i;

    // Reset with a beat offered: reset wins
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_err", a_out_err, 0);
    check("rst_err_count", a_err_count, 0);
    check("rst_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_c_out_valid", c_out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    a_in_valid = 1'b0;

    // Stream sel 0..15 at full rate
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      a_in_valid = (c < 16);
      a_sel = 4'(c);
      @(negedge clk);
      if (c < 16) check("t1_in_ready", a_in_ready, 1);
      if (c >= 2) begin
        check("t1_out_valid", a_out_valid, 1);
        check("t1_out_data", a_out_data, 32'h1000 + c - 2);
        check("t1_out_err", a_out_err, 0);
      end else begin
        check("t1_latency", a_out_valid, 0);
      end
    end
    check("t1_err_count", a_err_count, 0);

    // Backpressure
    k = 0; m = 0;
    for (int d = 0; d < 10; d++) begin
      @(posedge clk); #1;
      a_out_ready = (d >= 5);
      a_in_valid  = (k < 3);
      if (k < 3) a_sel = 4'(t2_sel[k]);
      @(negedge clk);
      if (d < 5) check("t2_in_ready", a_in_ready, (d < 2));
      if (d >= 2 && d < 5) check("t2_hold", {a_out_valid, a_out_data}, {1'b1, 32'h1003});
      if (a_in_valid && a_in_ready) k++;
      if (a_out_valid && a_out_ready) begin
        if (m < 3) check("t2_out_data", a_out_data, t2_exp[m]);
        else check("t2_extra_beat", 1, 0);
        m++;
      end
    end
    check("t2_beats_out", m, 3);
    check("t2_drained", a_out_valid, 0);

    // Out-of-range selects on 12-input instance
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      b_in_valid = (c < 3);
      if (c < 3) b_sel = 4'(t3_sel[c]);
      @(negedge clk);
      if (c >= 2) begin
        check("t3_out_valid", b_out_valid, 1);
        check("t3_out_data", b_out_data, t3_dat[c-2]);
        check("t3_out_err", b_out_err, t3_err[c-2]);
        check("t3_err_count", b_err_count, t3_cnt[c-2]);
      end
    end

    // Saturation of the 2-bit counter
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("t4_cleared", b_err_count, 0);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      b_in_valid = (c < 5);
      b_sel = 4'd13;
      @(negedge clk);
      if (c >= 2) begin
        check("t4_err_count", b_err_count, t4_cnt[c-2]);
        check("t4_out", {b_out_valid, b_out_err, b_out_data}, {2'b11, 32'h0});
      end
    end

    // Reset with both stages full
    @(posedge clk); #1; a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 4'd1;
    @(posedge clk); #1; a_sel = 4'd2;
    @(posedge clk); #1; a_sel = 4'd4;
    @(negedge clk);
    check("t5_full", {a_in_ready, a_out_valid}, 2'b01);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1; a_in_valid = 1'b0;
    @(negedge clk);
    check("t5_out_valid", a_out_valid, 0);
    check("t5_in_ready", a_in_ready, 1);
    check("t5_out_data", a_out_data, 0);
    check("t5_b_err_count", b_err_count, 0);
    a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_no_old_beat", a_out_valid, 0);
    end

    // Random handshakes against a scoreboard
    sent = 0; got = 0; errs = 0;
    for (int cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
      @(posedge clk); #1;
      c_in_valid  = (sent < 2000) && ($urandom_range(0, 3) != 0);
      c_sel       = 3'($urandom_range(0, 7));
      c_in_data   = {8'($urandom), 32'($urandom)};
      c_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (c_in_valid && c_in_ready) begin
        if (c_sel < 3'd5) begin
          q.push_back({1'b0, c_in_data[int'(c_sel)*8 +: 8]});
        end else begin
          q.push_back(9'h100);
          errs++;
        end
        sent++;
      end
      if (c_out_valid && c_out_ready) begin
        if (q.size() == 0) begin
          check("t6_spurious_beat", 1, 0);
        end else begin
          exp_beat = q.pop_front();
          check("t6_beat", {c_out_err, c_out_data}, exp_beat);
        end
        got++;
      end
    end
    check("t6_beats_out", got, 2000);
    check("t6_err_count", c_err_count, (errs > 255) ? 255 : errs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
